// File: rtl/ets_trace_replayer.sv
// Captures issue->retire latency per instruction, buffers it, and replays it as start/active/done waveforms.
// Latency: a retire is visible in fifo_level one cycle later; replay starts two edges after the push if idle.
// Backpressure: none toward the core; a push into a full FIFO is dropped (ovf_flag, drop_count when ETS_TRACE_DROP_CNT_EN).
module ets_trace_replayer #(
  parameter int DEPTH = 8,
  parameter int LAT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clr,
  input  logic                     cap_issue,
  input  logic [31:0]              cap_pc,
  input  logic [6:0]               cap_opcode,
  input  logic                     cap_retire,
  output logic                     instr_start,
  output logic                     instr_active,
  output logic                     instr_done,
  output logic [31:0]              instr_pc,
  output logic [6:0]               instr_opcode,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic                     ovf_flag,
`ifdef ETS_TRACE_DROP_CNT_EN
  output logic [15:0]              drop_count,
`endif
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

  typedef struct packed {
    logic [31:0]      pc;
    logic [6:0]       op;
    logic [LAT_W-1:0] lat;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  logic             out_q, out_d;
  logic [31:0]      cpc_q, cpc_d;
  logic [6:0]       cop_q, cop_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             push, perr_set;
  entry_t           push_ent;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             can_pop, push_ok, drop;
  entry_t           rd_ent;

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ipc_q, ipc_d;
  logic [6:0]       iop_q, iop_d;
  logic             ovf_q, ovf_d, perr_q, perr_d;
  logic [15:0]      drop_q, drop_d;

  // Capture side: track the single outstanding instruction and form the entry to push on retire.
  always_comb begin
    out_d    = out_q;
    cpc_d    = cpc_q;
    cop_d    = cop_q;
    lat_d    = lat_q;
    push     = 1'b0;
    push_ent = '0;
    perr_set = 1'b0;
    if (!enable) begin
      out_d = 1'b0;
    end else begin
      if (out_q && lat_q != LAT_MAX) lat_d = lat_q + LAT_W'(1);
      if (cap_retire) begin
        if (out_q) begin
          push         = 1'b1;
          push_ent.pc  = cpc_q;
          push_ent.op  = cop_q;
          push_ent.lat = (lat_q == '0) ? LAT_W'(1) : lat_q;
          out_d        = 1'b0;
        end else if (cap_issue) begin
          // Issue and retire in the same cycle with nothing pending: zero latency, clamped to 1.
          push         = 1'b1;
          push_ent.pc  = cap_pc;
          push_ent.op  = cap_opcode;
          push_ent.lat = LAT_W'(1);
        end else begin
          perr_set = 1'b1;
        end
      end
      if (cap_issue) begin
        if (out_q && !cap_retire) perr_set = 1'b1;
        if (out_q || !cap_retire) begin
          // Counter starts at 1 so its value on the retire cycle equals retire - issue.
          out_d = 1'b1;
          cpc_d = cap_pc;
          cop_d = cap_opcode;
          lat_d = LAT_W'(1);
        end
      end
    end
  end

  // FIFO bookkeeping; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    can_pop  = (state_q == IDLE || state_q == GAP) && enable && (level_q != '0);
    push_ok  = push && ((level_q != (AW+1)'(DEPTH)) || can_pop);
    drop     = push && !push_ok;
    rd_ent   = mem_q[rd_ptr_q];
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (can_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(can_pop);
  end

  // Replay FSM: the GAP cycle may pop so back-to-back entries sit exactly one idle cycle apart.
  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    cnt_d   = cnt_q;
    ipc_d   = ipc_q;
    iop_d   = iop_q;
    case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        if (can_pop) begin
          state_d = ACTIVE;
          first_d = 1'b1;
          cnt_d   = rd_ent.lat;
          ipc_d   = rd_ent.pc;
          iop_d   = rd_ent.op;
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) state_d = GAP;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky status; a new event in the clr cycle wins over the clear.
  always_comb begin
    ovf_d  = (clr ? 1'b0 : ovf_q) | drop;
    perr_d = (clr ? 1'b0 : perr_q) | perr_set;
    drop_d = clr ? 16'h0 : drop_q;
    if (drop && drop_d != 16'hFFFF) drop_d = drop_d + 16'h1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= 1'b0;
      cpc_q    <= '0;
      cop_q    <= '0;
      lat_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= IDLE;
      first_q  <= 1'b0;
      cnt_q    <= '0;
      ipc_q    <= '0;
      iop_q    <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      out_q    <= out_d;
      cpc_q    <= cpc_d;
      cop_q    <= cop_d;
      lat_q    <= lat_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
      ipc_q    <= ipc_d;
      iop_q    <= iop_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      drop_q   <= drop_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    instr_active = (state_q == ACTIVE);
    instr_start  = instr_active && first_q;
    instr_done   = instr_active && (cnt_q == '0);
    instr_pc     = ipc_q;
    instr_opcode = iop_q;
    fifo_level   = level_q;
    busy         = (state_q != IDLE);
    ovf_flag     = ovf_q;
    proto_err    = perr_q;
  end

`ifdef ETS_TRACE_DROP_CNT_EN
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_ets_trace_replayer.sv
module tb_ets_trace_replayer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clr = 1'b0;
  logic        cap_issue = 1'b0;
  logic [31:0] cap_pc = '0;
  logic [6:0]  cap_opcode = '0;
  logic        cap_retire = 1'b0;
  logic        instr_start, instr_active, instr_done, busy, ovf_flag, proto_err;
  logic [31:0] instr_pc;
  logic [6:0]  instr_opcode;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;

  ets_trace_replayer #(.DEPTH(8), .LAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
    .cap_issue(cap_issue), .cap_pc(cap_pc), .cap_opcode(cap_opcode), .cap_retire(cap_retire),
    .instr_start(instr_start), .instr_active(instr_active), .instr_done(instr_done),
    .instr_pc(instr_pc), .instr_opcode(instr_opcode), .fifo_level(fifo_level),
    .busy(busy), .ovf_flag(ovf_flag),
`ifdef ETS_TRACE_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .proto_err(proto_err)
  );
`ifndef ETS_TRACE_DROP_CNT_EN
  assign drop_count = 16'h0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
    int          n;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
    int          dly;
    int          exp_n;
  } vec_t;

  exp_t exp_q[$];
  int   gaps[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: measures start->done distance, active width and inter-instruction idle gap.
  int  start_cyc, done_cyc, act_cnt;
  bit  in_instr = 0, have_done = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_instr  = 0;
      have_done = 0;
    end else begin
      if (instr_start) begin
        if (have_done) gaps.push_back(cyc - done_cyc - 1);
        start_cyc = cyc;
        act_cnt   = 0;
        in_instr  = 1;
      end
      if (in_instr && instr_active) act_cnt++;
      if (instr_done) begin
        exp_t e;
        if (exp_q.size() == 0) begin
          chk("unexpected_replay", {32'h0, instr_pc}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("replay_pc", instr_pc, e.pc);
          chk("replay_op", instr_opcode, e.op);
          chk("replay_n", cyc - start_cyc, e.n);
          chk("active_width", act_cnt, e.n + 1);
        end
        in_instr  = 0;
        have_done = 1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_retire(input logic [31:0] pc, input logic [6:0] op, input int d, input bit expect_push);
    exp_t e;
    cap_pc = pc; cap_opcode = op; cap_issue = 1'b1;
    if (d == 0) cap_retire = 1'b1;
    step();
    cap_issue = 1'b0; cap_retire = 1'b0;
    if (d > 0) begin
      repeat (d - 1) step();
      cap_retire = 1'b1;
      step();
      cap_retire = 1'b0;
    end
    if (expect_push) begin
      e.pc = pc; e.op = op; e.n = (d == 0) ? 1 : d;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && fifo_level == 0 && exp_q.size() == 0) break;
    end
    chk("drain_in_budget", (i < budget), 1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h100, 7'h13, 5,  5};
    vecs[1] = '{32'h104, 7'h13, 10, 10};
    vecs[2] = '{32'h200, 7'h33, 0,  1};
    vecs[3] = '{32'h204, 7'h03, 1,  1};
    vecs[4] = '{32'h208, 7'h63, 2,  2};
    vecs[5] = '{32'h20C, 7'h6F, 3,  3};

    // Reset state
    #12;
    chk("rst_start", instr_start, 0);
    chk("rst_active", instr_active, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_op", instr_opcode, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_flag, 0);
    chk("rst_perr", proto_err, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    step();

    // Table-driven single instructions
    for (int i = 0; i < 6; i++) begin
      issue_retire(vecs[i].pc, vecs[i].op, vecs[i].dly, 1'b0);
      begin
        exp_t e;
        e.pc = vecs[i].pc; e.op = vecs[i].op; e.n = vecs[i].exp_n;
        exp_q.push_back(e);
      end
      @(negedge clk);
      chk("level_after_push", fifo_level, 1);
      wait_idle(100);
      chk("pc_held", instr_pc, vecs[i].pc);
    end

    // Three zero-latency instructions back to back: one idle cycle between replays
    for (int i = 0; i < 3; i++) issue_retire(32'h500 + 32'(4 * i), 7'h13, 0, 1'b1);
    wait_idle(100);
    chk("gap_1", gaps[gaps.size() - 2], 1);
    chk("gap_2", gaps[gaps.size() - 1], 1);

    // Overflow: long entry keeps FSM busy while 10 more arrive into 8 slots
    issue_retire(32'h600, 7'h13, 200, 1'b1);
    for (int i = 0; i < 10 && !busy; i++) step();
    chk("busy_long", busy, 1);
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      cap_pc = 32'h700 + 32'(4 * i); cap_opcode = 7'h23;
      cap_issue = 1'b1; cap_retire = 1'b1;
      if (i < 8) begin
        e.pc = cap_pc; e.op = cap_opcode; e.n = 1;
        exp_q.push_back(e);
      end
      step();
    end
    cap_issue = 1'b0; cap_retire = 1'b0;
    @(negedge clk);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_flag", ovf_flag, 1);
`ifdef ETS_TRACE_DROP_CNT_EN
    chk("drop_count", drop_count, 2);
`endif
    step();
    clr = 1'b1; step(); clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", ovf_flag, 0);
`ifdef ETS_TRACE_DROP_CNT_EN
    chk("drop_cleared", drop_count, 0);
`endif
    wait_idle(600);

    // Protocol errors: double issue replays only the second; lone retire flags
    cap_pc = 32'h800; cap_opcode = 7'h13; cap_issue = 1'b1; step(); cap_issue = 1'b0;
    step(); step();
    issue_retire(32'h804, 7'h33, 3, 1'b1);
    @(negedge clk);
    chk("perr_double_issue", proto_err, 1);
    wait_idle(100);
    clr = 1'b1; step(); clr = 1'b0;
    @(negedge clk);
    chk("perr_cleared", proto_err, 0);
    cap_retire = 1'b1; step(); cap_retire = 1'b0;
    @(negedge clk);
    chk("perr_lone_retire", proto_err, 1);
    clr = 1'b1; cap_retire = 1'b1; step(); clr = 1'b0; cap_retire = 1'b0;
    @(negedge clk);
    chk("perr_set_wins", proto_err, 1);
    chk("no_push_from_err", fifo_level, 0);

    // Disabled capture pushes nothing
    enable = 1'b0;
    issue_retire(32'h900, 7'h13, 3, 1'b0);
    @(negedge clk);
    chk("disabled_level", fifo_level, 0);
    chk("disabled_busy", busy, 0);
    enable = 1'b1;
    step();

    // Reset mid-ACTIVE aborts immediately
    issue_retire(32'hA00, 7'h13, 20, 1'b0);
    begin
      int i;
      for (i = 0; i < 20 && !instr_active; i++) @(negedge clk);
      chk("reached_active", instr_active, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_active", instr_active, 0);
    chk("async_busy", busy, 0);
    chk("async_level", fifo_level, 0);
    chk("async_perr", proto_err, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
